// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit with HI/LO registers (E stage).
// Ports: clk, reset, start, mdu_op, a, b, req -> busy, stall, hi, lo, rd_data.
module mdu_seq #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       mdu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             req,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] rd_data
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic issue;
   logic op_valid;

   logic [2*WIDTH-1:0]      prod_s;
   logic [2*WIDTH-1:0]      prod_u;
   logic                    ovf;
   logic                    div_zero;
   logic signed [WIDTH-1:0] sa;
   logic signed [WIDTH-1:0] sb;
   logic signed [WIDTH-1:0] q_s;
   logic signed [WIDTH-1:0] r_s;
   logic [WIDTH-1:0]        ub;
   logic [WIDTH-1:0]        q_u;
   logic [WIDTH-1:0]        r_u;

   assign issue    = start & ~req & ~busy;
   assign op_valid = (mdu_op >= OP_MULT) && (mdu_op <= OP_MTLO);
   assign stall    = busy | (start & op_valid);

   always_comb begin
      rd_data = '0;
      if (mdu_op == OP_MFHI) rd_data = hi;
      if (mdu_op == OP_MFLO) rd_data = lo;
   end

   // Signed product via sign extension; low 2*WIDTH bits are exact.
   assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} *
                   {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

   assign div_zero = (b_q == '0);
   assign ovf      = (a_q == MIN_NEG) && (b_q == '1);

   // Dividing by 1 on overflow yields q = a, r = 0 as required,
   // and also keeps the divider well-defined on a zero divisor.
   assign sa  = a_q;
   assign sb  = (div_zero || ovf) ? 1 : b_q;
   assign q_s = sa / sb;
   assign r_s = sa % sb;

   assign ub  = div_zero ? 1 : b_q;
   assign q_u = a_q / ub;
   assign r_u = a_q % ub;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  case (mdu_op)
                     OP_MULT, OP_MULTU: begin
                        op_q  <= mdu_op;
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= CW'(MULT_CYCLES);
                        state <= BUSY;
                        busy  <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        op_q  <= mdu_op;
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= CW'(DIV_CYCLES);
                        state <= BUSY;
                        busy  <= 1'b1;
                     end
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            BUSY: begin
               if (cnt == CW'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  case (op_q)
                     OP_MULT:  {hi, lo} <= prod_s;
                     OP_MULTU: {hi, lo} <= prod_u;
                     OP_DIV: begin
                        if (!div_zero) begin
                           hi <= r_s;
                           lo <= q_s;
                        end
                     end
                     OP_DIVU: begin
                        if (!div_zero) begin
                           hi <= r_u;
                           lo <= q_u;
                        end
                     end
                     default: ;
                  endcase
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq (vector table, corner
// sequences, randomized ops against an arithmetic reference model).
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        reset, start, req;
   logic [3:0]  mdu_op;
   logic [31:0] a, b;

   logic        busy, stall;
   logic [31:0] hi, lo, rd_data;
   logic        busy1, stall1;
   logic [31:0] hi1, lo1, rd1;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
      .a(a), .b(b), .req(req), .busy(busy), .stall(stall),
      .hi(hi), .lo(lo), .rd_data(rd_data)
   );

   mdu_seq #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut1 (
      .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
      .a(a), .b(b), .req(req), .busy(busy1), .stall(stall1),
      .hi(hi1), .lo(lo1), .rd_data(rd1)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] rd;
      int          lat;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         a = $urandom;
         b = $urandom;
         tick();
         n++;
      end
   endtask

   task automatic wait_idle1(output int n);
      n = 0;
      while (busy1 && n < 50) begin
         a = $urandom;
         b = $urandom;
         tick();
         n++;
      end
   endtask

   function automatic int exp_lat(input logic [3:0] op, input logic r);
      if (r) return 0;
      if (op == 1 || op == 2) return 5;
      if (op == 3 || op == 4) return 10;
      return 0;
   endfunction

   task automatic model_op(input logic [3:0] op,
                           input logic [31:0] x,
                           input logic [31:0] y,
                           input logic r);
      logic [63:0] p;
      int sx, sy;
      if (r) return;
      sx = x;
      sy = y;
      case (op)
         4'd1: begin
            p = longint'(sx) * longint'(sy);
            {m_hi, m_lo} = p;
         end
         4'd2: begin
            p = {32'b0, x} * {32'b0, y};
            {m_hi, m_lo} = p;
         end
         4'd3: begin
            if (y != 0) begin
               if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                  m_lo = x;
                  m_hi = 0;
               end else begin
                  m_lo = sx / sy;
                  m_hi = sx % sy;
               end
            end
         end
         4'd4: begin
            if (y != 0) begin
               m_lo = x / y;
               m_hi = x % y;
            end
         end
         4'd7: m_hi = x;
         4'd8: m_lo = x;
         default: ;
      endcase
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n1, bad;
      logic [3:0] rop;
      logic rreq;
      int sel;

      vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,
                   32'hFFFFFFFF, 32'hFFFFFFFA, 32'd0, 5};
      vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3,
                   32'h00000002, 32'hFFFFFFFA, 32'd0, 5};
      vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 32'hFFFFFFFD, 32'd0, 10};
      vecs[3]  = '{4'd4, 32'd7, 32'd2,
                   32'd1, 32'd3, 32'd0, 10};
      vecs[4]  = '{4'd7, 32'h11, 32'd9,
                   32'h11, 32'd3, 32'd0, 0};
      vecs[5]  = '{4'd8, 32'h22, 32'd9,
                   32'h11, 32'h22, 32'd0, 0};
      vecs[6]  = '{4'd3, 32'd5, 32'd0,
                   32'h11, 32'h22, 32'd0, 10};
      vecs[7]  = '{4'd5, 32'd0, 32'd0,
                   32'h11, 32'h22, 32'h11, 0};
      vecs[8]  = '{4'd6, 32'd0, 32'd0,
                   32'h11, 32'h22, 32'h22, 0};
      vecs[9]  = '{4'd4, 32'd9, 32'd0,
                   32'h11, 32'h22, 32'd0, 10};
      vecs[10] = '{4'd3, 32'h80000000, 32'hFFFFFFFF,
                   32'd0, 32'h80000000, 32'd0, 10};
      vecs[11] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'd0, 32'd1, 32'd0, 5};
      vecs[12] = '{4'd3, 32'd7, 32'hFFFFFFFE,
                   32'd1, 32'hFFFFFFFD, 32'd0, 10};
      vecs[13] = '{4'd0, 32'h1234, 32'h5678,
                   32'd1, 32'hFFFFFFFD, 32'd0, 0};
      vecs[14] = '{4'd9, 32'h1234, 32'h5678,
                   32'd1, 32'hFFFFFFFD, 32'd0, 0};

      reset  = 1'b1;
      start  = 1'b0;
      req    = 1'b0;
      mdu_op = 4'd0;
      a      = 32'h0;
      b      = 32'h0;
      tick();
      tick();
      reset = 1'b0;

      check("reset_busy", busy, 0);
      check("reset_stall", stall, 0);
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      check("reset_rd", rd_data, 0);

      for (int i = 0; i < 15; i++) begin
         start  = 1'b1;
         mdu_op = vecs[i].op;
         a      = vecs[i].a;
         b      = vecs[i].b;
         #1;
         check($sformatf("vec%0d_rd", i), rd_data, vecs[i].rd);
         check($sformatf("vec%0d_stall", i), stall,
               (vecs[i].op >= 1 && vecs[i].op <= 8));
         tick();
         start  = 1'b0;
         mdu_op = 4'd0;
         wait_idle(n);
         check($sformatf("vec%0d_lat", i), n, vecs[i].lat);
         check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      end
      m_hi = vecs[14].hi;
      m_lo = vecs[14].lo;

      for (int op = 1; op <= 8; op++) begin
         start  = 1'b1;
         req    = 1'b1;
         mdu_op = 4'(op);
         a      = $urandom;
         b      = 32'd1;
         tick();
         check($sformatf("req_op%0d_busy", op), busy, 0);
         start = 1'b0;
         req   = 1'b0;
         tick();
         check($sformatf("req_op%0d_hi", op), hi, m_hi);
         check($sformatf("req_op%0d_lo", op), lo, m_lo);
      end
      start  = 1'b1;
      mdu_op = 4'd8;
      a      = 32'd5;
      tick();
      start = 1'b0;
      m_lo  = 32'd5;
      check("mtlo_after_req", lo, 32'd5);
      check("mtlo_after_req_busy", busy, 0);

      start  = 1'b1;
      mdu_op = 4'd2;
      a      = 32'd3;
      b      = 32'd4;
      tick();
      mdu_op = 4'd8;
      a      = 32'hDEAD;
      tick();
      start = 1'b0;
      req   = 1'b1;
      wait_idle(n);
      req = 1'b0;
      check("busy_ignore_lat", n, 4);
      check("busy_ignore_hi", hi, 0);
      check("busy_ignore_lo", lo, 12);

      start  = 1'b1;
      mdu_op = 4'd3;
      a      = 32'd100;
      b      = 32'd7;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("midreset_still_busy", busy, 1);
      reset = 1'b1;
      tick();
      check("midreset_busy", busy, 0);
      check("midreset_hi", hi, 0);
      check("midreset_lo", lo, 0);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy || hi != 0 || lo != 0) bad++;
      end
      check("midreset_no_late_wb", bad, 0);

      start  = 1'b1;
      mdu_op = 4'd1;
      a      = 32'd6;
      b      = 32'd7;
      tick();
      start = 1'b0;
      wait_idle1(n1);
      check("fast_mult_lat", n1, 1);
      check("fast_mult_lo", lo1, 42);
      check("fast_mult_hi", hi1, 0);
      wait_idle(n);
      check("slow_mult_lat", n, 4);
      start  = 1'b1;
      mdu_op = 4'd4;
      a      = 32'd7;
      b      = 32'd2;
      tick();
      start = 1'b0;
      wait_idle1(n1);
      check("fast_div_lat", n1, 3);
      check("fast_div_hi", hi1, 1);
      check("fast_div_lo", lo1, 3);
      wait_idle(n);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hi = 0;
      m_lo = 0;
      for (int i = 0; i < 300; i++) begin
         rop  = 4'($urandom_range(0, 15));
         rreq = ($urandom_range(0, 7) == 0);
         a    = $urandom;
         sel  = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin
            a = 32'h80000000;
            b = 32'hFFFFFFFF;
         end else if (sel == 2) b = 32'($urandom_range(1, 20));
         else b = $urandom;
         start  = 1'b1;
         mdu_op = rop;
         req    = rreq;
         #1;
         if (rop == 5) check("rnd_mfhi", rd_data, m_hi);
         if (rop == 6) check("rnd_mflo", rd_data, m_lo);
         tick();
         start  = 1'b0;
         req    = 1'b0;
         mdu_op = 4'd0;
         model_op(rop, a, b, rreq);
         wait_idle(n);
         check($sformatf("rnd%0d_lat op%0d", i, rop), n,
               exp_lat(rop, rreq));
         check($sformatf("rnd%0d_hi op%0d", i, rop), hi, m_hi);
         check($sformatf("rnd%0d_lo op%0d", i, rop), lo, m_lo);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide unit for the 5-stage MIPS pipeline. Sits in the E stage.
- Consumes the control unit's MDUOp encoding: 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
- Holds the architectural HI/LO registers.
- Generalises the earlier fixed-latency scheme: data width, multiply latency and divide latency are parameters, and the unit adds exception-flush gating and divide-by-zero rules.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu; must be >= 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  E-stage instruction is an MDU instruction (MDUOp != 0).
- mdu_op  in  4  MDUOp encoding above. Values 0 and 9..15 are no-ops.
- a  in  WIDTH  forwarded rs value.
- b  in  WIDTH  forwarded rt value.
- req  in  1  exception/interrupt flush from the M stage. Cancels an issue in the same cycle.
- busy  out  1  a mult/div is in progress.
- stall  out  1  combinational: busy | (start & mdu_op in 1..8). The CU holds D and bubbles E when this is high.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd_data  out  WIDTH  combinational read: hi when mdu_op==5, lo when mdu_op==6, else 0.

Behaviour:
- Reset, checked at each rising edge: hi=0, lo=0, busy=0, counter=0, pending result discarded. Reset mid-operation aborts the operation, and HI/LO end at 0.
- Issue condition: start & !req & !busy.
- Issue is ignored when busy=1. The CU must not present one then because stall is already high.
- States: IDLE and BUSY.
- IDLE, issue with op 1..4:
  - Latch a, b and op.
  - Load counter with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4).
  - Go to BUSY; busy=1 from the next cycle.
- BUSY: decrement counter each cycle. When the counter reaches 1, at that edge:
  - Write the computed result to HI/LO.
  - Clear busy and return to IDLE.
- Total latency: busy is high for exactly N cycles after the issue edge. The new HI/LO is visible in the cycle busy first reads 0.
- IDLE, issue with op 7 (mthi): hi <= a at the next edge. busy stays 0.
- IDLE, issue with op 8 (mtlo): lo <= a at the next edge. busy stays 0.
- Ops 5 and 6 never change state. rd_data is valid combinationally even while busy, but the CU stalls them anyway.
- mult: {hi,lo} = signed a × signed b, full 2*WIDTH product.
- multu: {hi,lo} = unsigned a × unsigned b, full 2*WIDTH product.
- div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Signed overflow (a = most-negative value, b = -1): lo = a, hi = 0.
- Divide by zero (b==0, op 3 or 4): full DIV_CYCLES latency still elapses; HI and LO are left unchanged.
- req=1 in the issue cycle: nothing latched, busy stays 0, HI/LO unchanged for all ops 1..8.
- req during BUSY does not cancel. The operation was committed by an instruction that already retired past E.
- Compute may be behavioural (`*`, `/`, `%`) on the latched operands. The counter only models latency.
- Results depend only on the latched operands. Changes on a/b during BUSY have no effect.

Test Plan:
- Reset, then mult with a=0xFFFFFFFE (-2), b=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same with multu → hi=0x00000002, lo=0xFFFFFFFA.
- div with a=-7 (0xFFFFFFF9), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with a=7, b=2 → lo=3, hi=1.
- Preload hi=0x11, lo=0x22 via mthi/mtlo, then div with b=0 → busy for 10 cycles, hi=0x11, lo=0x22 unchanged. mfhi then gives rd_data=0x11.
- div with a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- start=1, op=1, req=1 → busy stays 0, HI/LO unchanged. Next cycle mtlo with a=5 and req=0 → lo=5.
- Issue div, assert reset on the 4th busy cycle → next edge busy=0, hi=lo=0, and no late write-back afterwards. Re-run with MULT_CYCLES=1 and DIV_CYCLES=3 → busy pulses of exactly 1 and 3 cycles.
